demux1x4_sched: RTL and testbench

Sequencing controller for the 1-to-4 demultiplexer path: accepts a stream of words on a single valid/ready input and dispatches each word to exactly one of four output channels. Destination is chosen per word, either fixed by a select input or by an internal round-robin pointer. A one-entry holding register decouples the input handshake from the outputs. The block sits between a single producer and four consumers, and replaces direct static drive of the demux select lines.

---
 rtl/demux1x4_sched.sv | 112 +++++++++++
 tb/tb_demux1x4_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1x4_sched.sv
// One-entry holding register that routes each accepted word to exactly one of
// four consumers, with the destination taken from sel or a strict round-robin pointer.
//
// Handshake: a word moves on any rising edge where valid and ready are both high.
// Once out_valid[i] rises, out_data and out_valid stay unchanged until out_ready[i].
// in_ready is combinational from out_ready, so the block accepts a new word
// on the same edge that the held word drains.
module demux1x4_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             mode,
    input  logic [1:0]       sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       cur_dest,
    output logic [1:0]       rr_ptr,
    output logic [15:0]      dispatch_cnt
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [1:0]       r_dest;
    logic [1:0]       r_rr_ptr;
    logic [15:0]      r_cnt;
    logic             w_drain;
    logic             w_accept;
    logic             w_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drain     = 1'b0;
        w_in_ready  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                w_in_ready = 1'b1;
                w_accept   = in_valid;
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                // Only the held word's own channel can release it; other readies are ignored.
                w_drain    = out_ready[r_dest];
                w_in_ready = w_drain;
                w_accept   = in_valid & w_drain;
                if (w_drain && !w_accept) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data   <= '0;
            r_dest   <= 2'd0;
            r_rr_ptr <= 2'd0;
            r_cnt    <= 16'd0;
        end else begin
            if (w_accept) begin
                r_data <= in_data;
                r_dest <= mode ? r_rr_ptr : sel;
            end
            // Strict rotation: the pointer advances per round-robin accept, never skipping.
            if (w_accept && mode) begin
                r_rr_ptr <= r_rr_ptr + 2'd1;
            end
            if (w_drain) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        in_ready     = w_in_ready;
        out_valid    = 4'b0000;
        out_data     = '0;
        cur_dest     = 2'd0;
        rr_ptr       = r_rr_ptr;
        dispatch_cnt = r_cnt;
        if (r_state == ST_FULL) begin
            out_valid = 4'b0001 << r_dest;
            out_data  = r_data;
            cur_dest  = r_dest;
        end
    end

endmodule

// File: tb/tb_demux1x4_sched.sv
// Bench for demux1x4_sched: directed scenarios plus random traffic, all checked
// by a queue-based scoreboard that models the holding register and rotation.
module tb_demux1x4_sched;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         mode;
  logic [1:0]   sel;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   cur_dest;
  logic [1:0]   rr_ptr;
  logic [15:0]  dispatch_cnt;

  int n_checks;
  int n_fail;

  // Scoreboard entry: {destination, data}.
  logic [W+1:0] exp_q[$];
  logic [1:0]   exp_rr;
  logic [15:0]  exp_cnt;
  logic         pend_v;
  logic         pend_rr;
  logic [W+1:0] pend_w;

  demux1x4_sched #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mode         (mode),
    .sel          (sel),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .cur_dest     (cur_dest),
    .rr_ptr       (rr_ptr),
    .dispatch_cnt (dispatch_cnt)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- issue side: record accepted words ----------------
  // Inputs only change just after a rising edge, so what is seen at the falling
  // edge is exactly what the next rising edge will sample.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      pend_v  = 1'b1;
      pend_rr = mode;
      pend_w  = {(mode ? exp_rr : sel), in_data};
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_rr = 2'd0;
      pend_v = 1'b0;
    end else if (pend_v) begin
      exp_q.push_back(pend_w);
      if (pend_rr) exp_rr = exp_rr + 2'd1;
      pend_v = 1'b0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W+1:0] head;
    logic         rdy;
    if (rst) begin
      exp_cnt = 16'd0;
      check("rst_out_valid", {28'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      check("rst_cnt", {16'd0, dispatch_cnt}, 32'd0);
      check("rst_rr", {30'd0, rr_ptr}, 32'd0);
    end else begin
      check("dispatch_cnt", {16'd0, dispatch_cnt}, {16'd0, exp_cnt});
      check("rr_ptr", {30'd0, rr_ptr}, {30'd0, exp_rr});
      if (exp_q.size() == 0) begin
        check("idle_out_valid", {28'd0, out_valid}, 32'd0);
        check("idle_out_data", {24'd0, out_data}, 32'd0);
        check("idle_cur_dest", {30'd0, cur_dest}, 32'd0);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
      end else begin
        head = exp_q[0];
        rdy  = out_ready[head[W+1:W]];
        check("out_valid", {28'd0, out_valid}, {28'd0, 4'b0001 << head[W+1:W]});
        check("out_data", {24'd0, out_data}, {24'd0, head[W-1:0]});
        check("cur_dest", {30'd0, cur_dest}, {30'd0, head[W+1:W]});
        check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        if (rdy) begin
          void'(exp_q.pop_front());
          exp_cnt = exp_cnt + 16'd1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drain_idle(input int n);
    in_valid  = 1'b0;
    out_ready = 4'hF;
    repeat (n) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_rr    = 2'd0;
    exp_cnt   = 16'd0;
    pend_v    = 1'b0;
    pend_rr   = 1'b0;
    pend_w    = '0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 4'hF;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Fixed destination, single word.
    step();
    mode = 1'b0; sel = 2'd2; in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("fixed_out_valid", {28'd0, out_valid}, 32'h4);
    check("fixed_out_data", {24'd0, out_data}, 32'hA5);
    @(negedge clk);
    check("fixed_cnt", {16'd0, dispatch_cnt}, 32'd1);
    check("fixed_empty", {28'd0, out_valid}, 32'd0);

    // Round-robin streaming, words 1..8.
    apply_reset();
    mode = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 8'(i); in_valid = 1'b1;
      @(negedge clk);
      check("rr_in_ready", {31'd0, in_ready}, 32'd1);
      if (i > 1) check("rr_dest", {28'd0, out_valid}, {28'd0, 4'b0001 << ((i - 2) % 4)});
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("rr_last_dest", {28'd0, out_valid}, 32'h8);
    @(negedge clk);
    check("rr_cnt", {16'd0, dispatch_cnt}, 32'd8);
    check("rr_ptr_end", {30'd0, rr_ptr}, 32'd0);

    // Backpressure on channel 1 with a second word waiting.
    step();
    mode = 1'b0; sel = 2'd1; in_data = 8'h3C; in_valid = 1'b1; out_ready = 4'b1101;
    step();
    in_data = 8'h77; sel = 2'd3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_out_valid", {28'd0, out_valid}, 32'h2);
      check("stall_out_data", {24'd0, out_data}, 32'h3C);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 4'hF;
    @(negedge clk);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("second_word_dest", {28'd0, out_valid}, 32'h8);
    check("second_word_data", {24'd0, out_data}, 32'h77);

    // Back-to-back destination change: channel 3 then channel 0.
    drain_idle(2);
    sel = 2'd3; in_data = 8'h11; in_valid = 1'b1;
    step();
    sel = 2'd0; in_data = 8'h22;
    @(negedge clk);
    check("b2b_first", {28'd0, out_valid}, 32'h8);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_second", {28'd0, out_valid}, 32'h1);
    check("b2b_second_data", {24'd0, out_data}, 32'h22);

    // Foreign readies ignored; sel/mode changes do not move the held word.
    drain_idle(2);
    mode = 1'b0; sel = 2'd2; in_data = 8'h55; in_valid = 1'b1; out_ready = 4'b1011;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sel  = 2'($urandom_range(0, 3));
      mode = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("held_cur_dest", {30'd0, cur_dest}, 32'd2);
      check("held_no_drain", {31'd0, in_ready}, 32'd0);
      step();
    end
    mode = 1'b0;
    drain_idle(2);

    // Reset while full.
    mode = 1'b1; in_data = 8'h9E; in_valid = 1'b1; out_ready = 4'h0;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_rr", {30'd0, rr_ptr}, 32'd1);
    check("pre_rst_full", {28'd0, out_valid}, 32'h1);
    step();
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", {28'd0, out_valid}, 32'd0);
    check("async_rst_rr", {30'd0, rr_ptr}, 32'd0);
    check("async_rst_cnt", {16'd0, dispatch_cnt}, 32'd0);
    step();
    rst = 1'b0;
    out_ready = 4'hF;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      step();
      in_valid  = 1'($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      out_ready = 4'($urandom);
    end
    drain_idle(3);

    // Counter wrap: 65536 drains from a fresh reset.
    apply_reset();
    mode = 1'b1; out_ready = 4'hF; in_valid = 1'b1;
    for (int c = 0; c < 65536; c++) begin
      in_data = 8'(c);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("wrap_pre", {16'd0, dispatch_cnt}, 32'hFFFF);
    @(negedge clk);
    check("wrap_zero", {16'd0, dispatch_cnt}, 32'd0);

    drain_idle(4);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
